// File: rtl/mem_dma_copy_pkg.sv
// mem_dma_copy_pkg: shared constants for the word-copy DMA initiator and the
// memory it drives. Holds the FSM state encodings, the bus widths, the word
// size in bytes, and a small alignment helper.
package mem_dma_copy_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    localparam logic [ADDR_W-1:0] WORD_BYTES = 32'd4;

    // Legacy-compatible state encodings
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RD   = 2'd1;
    localparam logic [1:0] ST_WR   = 2'd2;
    localparam logic [1:0] ST_FIN  = 2'd3;

    function automatic logic word_aligned(input logic [ADDR_W-1:0] a);
        return (a[1:0] == 2'b00);
    endfunction

endpackage

// File: rtl/mem_dma_copy_if.sv
// mem_dma_copy_if: single-port word memory bus.
//   mem_read  - read strobe (data_in is valid combinationally in the same cycle)
//   mem_write - write strobe (memory commits data_out at the next posedge)
//   address   - byte address
//   data_in   - read data from memory
//   data_out  - write data to memory
// Modports: master = bus initiator (DMA), slave = memory.
interface mem_dma_copy_if;
    import mem_dma_copy_pkg::*;

    logic              mem_read;
    logic              mem_write;
    logic [ADDR_W-1:0] address;
    logic [DATA_W-1:0] data_in;
    logic [DATA_W-1:0] data_out;

    modport master (output mem_read, mem_write, address, data_out, input  data_in);
    modport slave  (input  mem_read, mem_write, address, data_out, output data_in);
endinterface

// File: rtl/mem_dma_ptr.sv
// mem_dma_ptr: 32-bit byte-address pointer, loadable, with a one-word (+4)
// increment enable. Wraps modulo 2^32.
//   clk, reset - clock, synchronous active-high reset (ptr -> 0)
//   load       - load load_val (has priority over inc)
//   load_val   - value to load
//   inc        - advance by one word
//   ptr        - current pointer value
module mem_dma_ptr
    import mem_dma_copy_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [ADDR_W-1:0] load_val,
    input  logic              inc,
    output logic [ADDR_W-1:0] ptr
);

    always_ff @(posedge clk) begin
        if (reset)     ptr <= '0;
        else if (load) ptr <= load_val;
        else if (inc)  ptr <= ptr + WORD_BYTES;
    end

endmodule

// File: rtl/mem_dma_copy.sv
// mem_dma_copy: copies word_count aligned 32-bit words from src_addr to
// dst_addr over a single-port memory bus, one read then one write per word,
// ascending addresses.
//   clk, reset  - clock, synchronous active-high reset
//   start       - one-cycle request, only looked at in IDLE
//   src_addr    - byte address of first source word
//   dst_addr    - byte address of first destination word
//   word_count  - words to copy (0 is legal: done without any access)
//   bus         - memory bus (master side)
//   busy        - high in any state other than IDLE
//   done        - one-cycle pulse when the copy completes
//   error       - one-cycle pulse when start was rejected for misalignment
module mem_dma_copy
    import mem_dma_copy_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic [CNT_W-1:0]  word_count,
    mem_dma_copy_if.master    bus,
    output logic              busy,
    output logic              done,
    output logic              error
);

    logic [1:0]        state;
    logic [CNT_W-1:0]  rem;
    logic [DATA_W-1:0] rdata;
    logic [ADDR_W-1:0] addr_q;
    logic              err_q;
    logic [ADDR_W-1:0] src_ptr;
    logic [ADDR_W-1:0] dst_ptr;
    logic [ADDR_W-1:0] addr_mux;

    logic accept;
    logic aligned;
    logic load;

    assign accept  = (state == ST_IDLE) && start;
    assign aligned = word_aligned(src_addr) && word_aligned(dst_addr);
    assign load    = accept && aligned && (word_count != '0);

    mem_dma_ptr u_src_ptr (
        .clk      (clk),
        .reset    (reset),
        .load     (load),
        .load_val (src_addr),
        .inc      (state == ST_RD),
        .ptr      (src_ptr)
    );

    mem_dma_ptr u_dst_ptr (
        .clk      (clk),
        .reset    (reset),
        .load     (load),
        .load_val (dst_addr),
        .inc      (state == ST_WR),
        .ptr      (dst_ptr)
    );

    // Outside RD/WR the address holds whatever was last driven.
    always_comb begin
        addr_mux = addr_q;
        case (state)
            ST_RD:   addr_mux = src_ptr;
            ST_WR:   addr_mux = dst_ptr;
            default: addr_mux = addr_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= ST_IDLE;
            rem    <= '0;
            rdata  <= '0;
            addr_q <= '0;
            err_q  <= 1'b0;
        end else begin
            err_q  <= accept && !aligned;
            addr_q <= addr_mux;
            case (state)
                ST_IDLE: begin
                    if (accept && aligned) begin
                        if (word_count == '0) begin
                            state <= ST_FIN;
                        end else begin
                            rem   <= word_count;
                            state <= ST_RD;
                        end
                    end
                end
                ST_RD: begin
                    rdata <= bus.data_in;
                    state <= ST_WR;
                end
                ST_WR: begin
                    rem   <= rem - 1'b1;
                    state <= (rem == CNT_W'(1)) ? ST_FIN : ST_RD;
                end
                ST_FIN:  state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Strobes are decoded from the registered state, but a reset held during
    // a RD/WR cycle also kills that cycle's strobe so the memory does not
    // commit a write on the same edge the copy is abandoned.
    assign bus.mem_read  = (state == ST_RD) && !reset;
    assign bus.mem_write = (state == ST_WR) && !reset;
    assign bus.address   = addr_mux;
    assign bus.data_out  = rdata;

    assign busy  = (state != ST_IDLE);
    assign done  = (state == ST_FIN);
    assign error = err_q;

endmodule

// File: tb/tb_mem_dma_copy.sv
module tb_mem_dma_copy;

    localparam logic [31:0] OOW_DATA = 32'hBAD0_BAD0;  // read value outside the window
    localparam int          NWORDS   = 32;             // 128-byte window at base 0

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] src_addr, dst_addr;
    logic [7:0]  word_count;
    logic        busy, done, error;

    mem_dma_copy_if bus ();

    mem_dma_copy #(.CNT_W(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .src_addr   (src_addr),
        .dst_addr   (dst_addr),
        .word_count (word_count),
        .bus        (bus),
        .busy       (busy),
        .done       (done),
        .error      (error)
    );

    always #5 clk = ~clk;

    // Memory: combinational read, write on posedge; a bench-side port preloads it.
    logic [31:0] mem [0:NWORDS-1];
    logic        tb_we = 1'b0;
    logic [4:0]  tb_idx = '0;
    logic [31:0] tb_wdata = '0;

    assign bus.data_in = (bus.address < 32'd128) ? mem[bus.address[6:2]] : OOW_DATA;

    always @(posedge clk) begin
        if (tb_we)
            mem[tb_idx] <= tb_wdata;
        else if (bus.mem_write && bus.address < 32'd128)
            mem[bus.address[6:2]] <= bus.data_out;
    end

    // Bus monitor
    int          rd_cnt = 0, wr_cnt = 0, done_cnt = 0, err_cnt = 0;
    logic [31:0] rd_q [$];

    always @(posedge clk) begin
        if (bus.mem_read) begin
            rd_cnt <= rd_cnt + 1;
            rd_q.push_back(bus.address);
        end
        if (bus.mem_write) wr_cnt   <= wr_cnt + 1;
        if (done)          done_cnt <= done_cnt + 1;
        if (error)         err_cnt  <= err_cnt + 1;
    end

    // Reference model: memory image plus an ascending word-by-word copy.
    logic [31:0] ref_mem [0:NWORDS-1];

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        return (a < 32'd128) ? ref_mem[a[6:2]] : OOW_DATA;
    endfunction

    task automatic model_copy(input logic [31:0] s, input logic [31:0] d, input int n);
        logic [31:0] w, da;
        for (int i = 0; i < n; i++) begin
            w  = ref_rd(s + 32'(4 * i));
            da = d + 32'(4 * i);
            if (da < 32'd128) ref_mem[da[6:2]] = w;
        end
    endtask

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic poke(input int idx, input logic [31:0] v);
        tb_idx   = 5'(idx);
        tb_wdata = v;
        tb_we    = 1'b1;
        @(negedge clk);
        tb_we    = 1'b0;
        ref_mem[idx] = v;
    endtask

    task automatic chk_mem(input string tag);
        for (int i = 0; i < NWORDS; i++)
            chk($sformatf("%s mem[0x%02h]", tag, i * 4), mem[i], ref_mem[i]);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, " mem_read"},  32'(bus.mem_read),  32'd0);
        chk({tag, " mem_write"}, 32'(bus.mem_write), 32'd0);
        chk({tag, " address"},   bus.address,        32'd0);
        chk({tag, " data_out"},  bus.data_out,       32'd0);
        chk({tag, " busy"},      32'(busy),          32'd0);
        chk({tag, " done"},      32'(done),          32'd0);
        chk({tag, " error"},     32'(error),         32'd0);
    endtask

    // Issue a one-cycle start and wait (bounded) for done.
    // cyc = cycles from the start edge to the cycle done is seen high.
    task automatic run_copy(input logic [31:0] s, input logic [31:0] d, input int n,
                            output int cyc, output bit busy_ok);
        src_addr   = s;
        dst_addr   = d;
        word_count = n[7:0];
        start      = 1'b1;
        @(negedge clk);
        start   = 1'b0;
        cyc     = 1;
        busy_ok = 1'b1;
        while (!done && cyc < 2 * n + 10) begin
            if (!busy) busy_ok = 1'b0;
            @(negedge clk);
            cyc++;
        end
        if (!busy) busy_ok = 1'b0;
    endtask

    task automatic copy_and_check(input string tag, input logic [31:0] s,
                                  input logic [31:0] d, input int n);
        int cyc, r0, w0;
        bit bok;
        r0 = rd_cnt;
        w0 = wr_cnt;
        run_copy(s, d, n, cyc, bok);
        model_copy(s, d, n);
        chk({tag, " latency"}, 32'(cyc), 32'(2 * n + 1));
        chk({tag, " busy"},    32'(bok), 32'd1);
        @(negedge clk);
        chk({tag, " done one cycle"}, 32'(done), 32'd0);
        chk({tag, " idle after"},     32'(busy), 32'd0);
        chk({tag, " rd strobes"},     32'(rd_cnt - r0), 32'(n));
        chk({tag, " wr strobes"},     32'(wr_cnt - w0), 32'(n));
        chk_mem(tag);
    endtask

    initial begin
        int          cyc, n, si, di, r0, w0, e0, d0, q0;
        bit          bok;
        logic [31:0] b0;

        reset = 1'b1; start = 1'b0;
        src_addr = '0; dst_addr = '0; word_count = '0;
        @(negedge clk);
        @(negedge clk);
        chk_reset_outputs("reset");

        // start together with reset: reset wins
        src_addr = 32'h0; dst_addr = 32'h40; word_count = 8'd1; start = 1'b1;
        @(negedge clk);
        chk("start+reset busy", 32'(busy), 32'd0);
        start = 1'b0;
        reset = 1'b0;

        for (int i = 0; i < NWORDS; i++) poke(i, $urandom);

        // 1. basic four-word copy
        copy_and_check("t1", 32'h00, 32'h40, 4);

        // 2. zero-length copy
        copy_and_check("t2", 32'h10, 32'h20, 0);

        // 3. misaligned src, then misaligned dst
        for (int k = 0; k < 2; k++) begin
            e0 = err_cnt; r0 = rd_cnt; w0 = wr_cnt;
            src_addr   = (k == 0) ? 32'h02 : 32'h00;
            dst_addr   = (k == 0) ? 32'h40 : 32'h41;
            word_count = 8'd3;
            start      = 1'b1;
            @(negedge clk);
            start = 1'b0;
            chk($sformatf("t3.%0d error pulse", k), 32'(error), 32'd1);
            chk($sformatf("t3.%0d busy", k),        32'(busy),  32'd0);
            @(negedge clk);
            chk($sformatf("t3.%0d error drop", k),  32'(error), 32'd0);
            chk($sformatf("t3.%0d err count", k),   32'(err_cnt - e0), 32'd1);
            chk($sformatf("t3.%0d no access", k),   32'((rd_cnt - r0) + (wr_cnt - w0)), 32'd0);
        end
        chk_mem("t3");

        // 4. reset during the second WR cycle
        for (int i = 0; i < 8; i++) poke(i, $urandom);
        src_addr = 32'h00; dst_addr = 32'h40; word_count = 8'd8; start = 1'b1;
        @(negedge clk);
        start = 1'b0;                  // cycle 1: RD
        @(negedge clk);                // cycle 2: WR (first word)
        @(negedge clk);                // cycle 3: RD
        @(negedge clk);                // cycle 4: WR (second word)
        reset = 1'b1;
        @(negedge clk);
        chk_reset_outputs("t4 after reset");
        reset = 1'b0;
        model_copy(32'h00, 32'h40, 1);
        chk_mem("t4");
        copy_and_check("t4 restart", 32'h20, 32'h60, 3);

        // 5. start pulses while busy are ignored
        d0 = done_cnt;
        src_addr = 32'h00; dst_addr = 32'h40; word_count = 8'd2; start = 1'b1;
        @(negedge clk);
        for (int k = 1; k <= 3; k++) begin
            src_addr = 32'h10 * k; dst_addr = 32'h50; word_count = 8'd5;
            @(negedge clk);
        end
        start = 1'b0;
        cyc = 0;
        while (done_cnt == d0 && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        repeat (4) @(negedge clk);
        chk("t5 one done", 32'(done_cnt - d0), 32'd1);
        chk("t5 idle", 32'(busy), 32'd0);
        model_copy(32'h00, 32'h40, 2);
        chk_mem("t5");

        // 5b. source pointer wraps past 2^32
        q0 = rd_q.size();
        run_copy(32'hFFFF_FFFC, 32'h60, 2, cyc, bok);
        model_copy(32'hFFFF_FFFC, 32'h60, 2);
        chk("t5b latency", 32'(cyc), 32'd5);
        chk("t5b reads", 32'(rd_q.size() - q0), 32'd2);
        if (rd_q.size() >= q0 + 2) begin
            chk("t5b rd addr 0", rd_q[q0],     32'hFFFF_FFFC);
            chk("t5b rd addr 1", rd_q[q0 + 1], 32'h0000_0000);
        end
        @(negedge clk);
        chk_mem("t5b");

        // 6. overlapping ranges, dst = src + 4
        b0 = $urandom;
        poke(0, b0);
        poke(1, $urandom);
        copy_and_check("t6", 32'h00, 32'h04, 2);
        chk("t6 mem[0x04]", mem[1], b0);
        chk("t6 mem[0x08]", mem[2], b0);

        // randomized aligned copies inside the window
        for (int k = 0; k < 4; k++) begin
            n  = $urandom_range(1, 8);
            si = $urandom_range(0, NWORDS - n);
            di = $urandom_range(0, NWORDS - n);
            copy_and_check($sformatf("rnd%0d", k), 32'(si * 4), 32'(di * 4), n);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
